// File: rtl/misr_periph_responder.sv
// Two-register MISR peripheral with SRAM response pass-through and a one-cycle response pipeline.
// Optional build macro MISR_CLEAR_ON_READ_EN: a legal read reloads the read MISR to MISR_SEED.
module misr_periph_responder #(
    parameter int                        NBIT_MISR_DATA = 32,
    parameter int                        NBIT_AXI_WIDTH = 64,
    parameter int                        USER_AXI_WIDTH = 10,
    parameter logic [NBIT_MISR_DATA-1:0] MISR_POLY      = 32'h04C11DB7,
    parameter logic [NBIT_MISR_DATA-1:0] MISR_SEED      = 32'h00000000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                re_misr_i,
    input  logic [1:0]                we_misr_i,
    input  logic [NBIT_MISR_DATA-1:0] data_misr_i,
    input  logic [USER_AXI_WIDTH-1:0] user_i,
    input  logic                      sram_req_i,
    input  logic [NBIT_AXI_WIDTH-1:0] sram_rdata_i,
    input  logic [USER_AXI_WIDTH-1:0] sram_ruser_i,
    output logic                      rvalid_o,
    output logic [NBIT_AXI_WIDTH-1:0] rdata_o,
    output logic [USER_AXI_WIDTH-1:0] ruser_o,
    output logic                      err_o,
    output logic [1:0]                src_dbg
);

    // Handshake: any strobe is a request; rvalid_o pulses exactly one cycle later.
    // There is no ready, so the consumer must accept every rvalid_o pulse.
    typedef enum logic [1:0] {S_IDLE, S_SRAM, S_MISR_RD, S_MISR_WR} src_t;

    src_t                      src_q;
    src_t                      src_next;
    logic [NBIT_MISR_DATA-1:0] misr [2];
    logic [NBIT_MISR_DATA-1:0] rd_q;
    logic [USER_AXI_WIDTH-1:0] user_q;
    logic                      err_q;

    logic re_any;
    logic we_any;
    logic req;
    logic illegal;
    logic rd_legal;
    logic wr_legal;

    function automatic logic [NBIT_MISR_DATA-1:0] misr_step(
        input logic [NBIT_MISR_DATA-1:0] cur,
        input logic [NBIT_MISR_DATA-1:0] din
    );
        return {cur[NBIT_MISR_DATA-2:0], 1'b0}
             ^ (cur[NBIT_MISR_DATA-1] ? MISR_POLY : '0)
             ^ din;
    endfunction

    assign re_any   = |re_misr_i;
    assign we_any   = |we_misr_i;
    assign req      = re_any | we_any | sram_req_i;
    assign illegal  = (&re_misr_i) | (&we_misr_i) | (re_any & we_any)
                    | ((re_any | we_any) & sram_req_i);
    assign rd_legal = re_any & ~illegal;
    assign wr_legal = we_any & ~illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) src_q <= S_IDLE;
        else       src_q <= src_next;
    end

    // Illegal requests without SRAM reuse the write path: valid response, zero data.
    always_comb begin
        src_next = S_IDLE;
        if (sram_req_i)   src_next = S_SRAM;
        else if (illegal) src_next = S_MISR_WR;
        else if (re_any)  src_next = S_MISR_RD;
        else if (we_any)  src_next = S_MISR_WR;
    end

    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = '0;
        ruser_o  = '0;
        case (src_q)
            S_SRAM: begin
                rvalid_o = 1'b1;
                rdata_o  = sram_rdata_i;
                ruser_o  = sram_ruser_i;
            end
            S_MISR_RD: begin
                rvalid_o                     = 1'b1;
                rdata_o[NBIT_MISR_DATA-1:0]  = rd_q;
                ruser_o                      = user_q;
            end
            S_MISR_WR: begin
                rvalid_o = 1'b1;
                ruser_o  = user_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misr[0] <= MISR_SEED;
            misr[1] <= MISR_SEED;
            rd_q    <= '0;
            user_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= illegal;
            if (req)      user_q <= user_i;
            if (rd_legal) rd_q   <= re_misr_i[1] ? misr[1] : misr[0];
            for (int k = 0; k < 2; k++) begin
                if (wr_legal && we_misr_i[k]) misr[k] <= misr_step(misr[k], data_misr_i);
`ifdef MISR_CLEAR_ON_READ_EN
                if (rd_legal && re_misr_i[k]) misr[k] <= MISR_SEED;
`endif
            end
        end
    end

    assign err_o   = err_q;
    assign src_dbg = src_q;

endmodule
